midi_note_receiver: RTL and testbench



---
 rtl/midi_pkg.sv | 23 ++
 rtl/midi_uart_rx.sv | 98 +++++++++
 rtl/midi_note_receiver.sv | 98 +++++++++
 tb/tb_midi_note_receiver.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/midi_pkg.sv
// Shared constants and state types for the MIDI note receiver.
package midi_pkg;

    localparam logic [3:0] NOTE_OFF     = 4'h8;
    localparam logic [3:0] NOTE_ON      = 4'h9;
    localparam logic [7:0] REALTIME_MIN = 8'hF8;
    localparam logic [6:0] DEFAULT_NOTE = 7'd69;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP,
        UART_WAIT_HIGH
    } uart_state_t;

    typedef enum logic [1:0] {
        NO_STATUS,
        WAIT_KEY,
        WAIT_VEL
    } parse_state_t;

endpackage

// File: rtl/midi_uart_rx.sv
// MIDI UART receiver: input synchroniser plus 8N1 deserialiser.
module midi_uart_rx
    import midi_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000,
    parameter int BAUD   = 31_250
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_rx,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int BIT_CYCLES  = CLK_HZ / BAUD;
    localparam int HALF_CYCLES = BIT_CYCLES / 2;
    localparam int CW          = $clog2(BIT_CYCLES);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

    logic          rx_s1, rx_s2, rx_d;
    logic          fall, tick;
    logic          bv_nx, fe_nx;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;
    uart_state_t   state, state_nx;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_d  <= 1'b1;
        end else begin
            rx_s1 <= midi_rx;
            rx_s2 <= rx_s1;
            rx_d  <= rx_s2;
        end
    end

    assign fall = rx_d & ~rx_s2;
    // START times half a bit so later samples land mid-bit
    assign tick = (state == UART_START) ? (cnt == HALF_LAST)
                                        : (cnt == BIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= UART_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            UART_IDLE:      if (fall) state_nx = UART_START;
            UART_START:     if (tick) state_nx = rx_s2 ? UART_IDLE : UART_DATA;
            UART_DATA:      if (tick && bit_idx == 3'd7) state_nx = UART_STOP;
            UART_STOP:      if (tick) state_nx = rx_s2 ? UART_IDLE : UART_WAIT_HIGH;
            UART_WAIT_HIGH: if (rx_s2) state_nx = UART_IDLE;
            default:        state_nx = UART_IDLE;
        endcase
    end

    always_comb begin
        bv_nx = 1'b0;
        fe_nx = 1'b0;
        if (state == UART_STOP && tick) begin
            bv_nx = rx_s2;
            fe_nx = ~rx_s2;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            bit_idx    <= 3'd0;
            shift      <= 8'd0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            byte_valid <= bv_nx;
            frame_err  <= fe_nx;
            if (state_nx != state || tick)
                cnt <= '0;
            else if (state == UART_START || state == UART_DATA || state == UART_STOP)
                cnt <= cnt + 1'b1;
            if (state != UART_DATA)
                bit_idx <= 3'd0;
            else if (tick && bit_idx != 3'd7)
                bit_idx <= bit_idx + 3'd1;
            if (state == UART_DATA && tick)
                shift <= {rx_s2, shift[7:1]};
        end
    end

    assign data = shift;

endmodule

// File: rtl/midi_note_receiver.sv
// MIDI input: UART receive plus monophonic Note On/Off parser with running status.
module midi_note_receiver
    import midi_pkg::*;
#(
    parameter int CLK_HZ  = 50_000_000,
    parameter int BAUD    = 31_250,
    parameter int OMNI    = 1,
    parameter int CHANNEL = 0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       midi_rx,
    output logic [6:0] note,
    output logic [6:0] volume,
    output logic       gate,
    output logic       note_strobe,
    output logic       frame_err
);

    logic [7:0]   rx_byte;
    logic         byte_valid;
    logic         is_data, is_voice, is_rt, is_other, chan_ok;
    logic         note_on_q;
    logic [6:0]   key_q;
    logic         apply, do_on, do_off;
    parse_state_t pstate, pstate_nx;

    midi_uart_rx #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_uart (
        .clk       (clk),
        .reset     (reset),
        .midi_rx   (midi_rx),
        .data      (rx_byte),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    assign is_data  = ~rx_byte[7];
    assign is_rt    = rx_byte >= REALTIME_MIN;
    assign is_voice = (rx_byte[7:4] == NOTE_OFF) || (rx_byte[7:4] == NOTE_ON);
    assign is_other = rx_byte[7] & ~is_voice & ~is_rt;
    assign chan_ok  = (OMNI != 0) || (rx_byte[3:0] == CHANNEL[3:0]);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) pstate <= NO_STATUS;
        else       pstate <= pstate_nx;
    end

    // Realtime bytes leave the message state untouched
    always_comb begin
        pstate_nx = pstate;
        if (byte_valid) begin
            unique case (1'b1)
                is_rt:    pstate_nx = pstate;
                is_voice: pstate_nx = chan_ok ? WAIT_KEY : NO_STATUS;
                is_other: pstate_nx = NO_STATUS;
                is_data: begin
                    if (pstate == WAIT_KEY)      pstate_nx = WAIT_VEL;
                    else if (pstate == WAIT_VEL) pstate_nx = WAIT_KEY;
                end
            endcase
        end
    end

    always_comb begin
        apply  = byte_valid & is_data & (pstate == WAIT_VEL);
        do_on  = apply & note_on_q & (rx_byte[6:0] != 7'd0);
        do_off = apply & ~do_on & (key_q == note) & gate;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            note        <= DEFAULT_NOTE;
            volume      <= 7'd0;
            gate        <= 1'b0;
            note_strobe <= 1'b0;
            note_on_q   <= 1'b0;
            key_q       <= 7'd0;
        end else begin
            note_strobe <= do_on | do_off;
            if (byte_valid && is_voice && chan_ok)
                note_on_q <= (rx_byte[7:4] == NOTE_ON);
            if (byte_valid && is_data && pstate == WAIT_KEY)
                key_q <= rx_byte[6:0];
            if (do_on) begin
                note   <= key_q;
                volume <= rx_byte[6:0];
                gate   <= 1'b1;
            end else if (do_off) begin
                volume <= 7'd0;
                gate   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_midi_note_receiver.sv
// Bench: an omni receiver and a channel-2 receiver share one serial line.
module tb_midi_note_receiver;

    localparam int CLK_HZ = 160_000;
    localparam int BAUD   = 10_000;
    localparam int BITC   = CLK_HZ / BAUD;
    localparam int HALF   = BITC / 2;

    logic       clk = 1'b0;
    logic       reset;
    logic       midi_rx;
    logic [6:0] note0, vol0, note1, vol1;
    logic       gate0, stb0, fe0, gate1, stb1, fe1;

    midi_note_receiver #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OMNI(1), .CHANNEL(0)
    ) dut0 (
        .clk(clk), .reset(reset), .midi_rx(midi_rx),
        .note(note0), .volume(vol0), .gate(gate0),
        .note_strobe(stb0), .frame_err(fe0)
    );

    midi_note_receiver #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .OMNI(0), .CHANNEL(2)
    ) dut1 (
        .clk(clk), .reset(reset), .midi_rx(midi_rx),
        .note(note1), .volume(vol1), .gate(gate1),
        .note_strobe(stb1), .frame_err(fe1)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int t_start = 0;
    int stb_cnt[2];
    int fe_cnt[2];
    int last_stb[2];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (stb0) begin stb_cnt[0]++; last_stb[0] = cyc; end
        if (stb1) begin stb_cnt[1]++; last_stb[1] = cyc; end
        if (fe0) fe_cnt[0]++;
        if (fe1) fe_cnt[1]++;
    end

    // Reference model: message assembly from running status and data bytes
    int m_rs[2];
    int m_cnt[2];
    int m_data[2][2];
    int m_note[2], m_vol[2], m_gate[2], m_stb[2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rs[d] = 0; m_cnt[d] = 0;
            m_note[d] = 69; m_vol[d] = 0; m_gate[d] = 0;
        end
    endtask

    task automatic model_byte(input int d, input logic [7:0] b);
        int key, vel;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            m_cnt[d] = 0;
            if ((b[7:5] == 3'b100) && (d == 0 || b[3:0] == 4'd2))
                m_rs[d] = int'(b);
            else
                m_rs[d] = 0;
            return;
        end
        if (m_rs[d] == 0) return;
        m_data[d][m_cnt[d]] = int'(b);
        m_cnt[d]++;
        if (m_cnt[d] < 2) return;
        m_cnt[d] = 0;
        key = m_data[d][0];
        vel = m_data[d][1];
        if (m_rs[d] >= 'h90 && vel != 0) begin
            m_note[d] = key; m_vol[d] = vel; m_gate[d] = 1; m_stb[d]++;
        end else if (key == m_note[d] && m_gate[d] == 1) begin
            m_vol[d] = 0; m_gate[d] = 0; m_stb[d]++;
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int get_note(input int d);
        return d ? int'(note1) : int'(note0);
    endfunction
    function automatic int get_vol(input int d);
        return d ? int'(vol1) : int'(vol0);
    endfunction
    function automatic int get_gate(input int d);
        return d ? int'(gate1) : int'(gate0);
    endfunction

    task automatic check_dut(input string tag, input int first);
        for (int d = first; d < 2; d++) begin
            check($sformatf("%s dut%0d note", tag, d), get_note(d), m_note[d]);
            check($sformatf("%s dut%0d vol", tag, d), get_vol(d), m_vol[d]);
            check($sformatf("%s dut%0d gate", tag, d), get_gate(d), m_gate[d]);
            check($sformatf("%s dut%0d strobes", tag, d), stb_cnt[d], m_stb[d]);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk);
        t_start = cyc;
        midi_rx = 1'b0;
        repeat (BITC) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            midi_rx = b[i];
            repeat (BITC) @(negedge clk);
        end
        midi_rx = stop;
        repeat (BITC) @(negedge clk);
        midi_rx = 1'b1;
    endtask

    task automatic feed(input logic [7:0] b);
        model_byte(0, b);
        model_byte(1, b);
        send_byte(b, 1'b1);
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    typedef struct {
        int          nb;
        logic [31:0] bytes;
        int          note;
        int          vol;
        int          gate;
        int          stb;
    } vec_t;

    vec_t vec[14];
    logic [7:0] keys[4];

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, f0, f1, kind, delta;
        logic [7:0] ch, key, vel, bb;

        keys[0] = 8'd60; keys[1] = 8'd62; keys[2] = 8'd64; keys[3] = 8'd67;
        vec[0]  = '{3, 32'h903C6400, 60, 100, 1, 1};
        vec[1]  = '{2, 32'h40500000, 64, 80, 1, 1};
        vec[2]  = '{2, 32'h40000000, 64, 0, 0, 1};
        vec[3]  = '{3, 32'h903C6400, 60, 100, 1, 1};
        vec[4]  = '{3, 32'h803E0000, 60, 100, 1, 0};
        vec[5]  = '{4, 32'h903CF864, 60, 100, 1, 1};
        vec[6]  = '{3, 32'h91302000, 48, 32, 1, 1};
        vec[7]  = '{3, 32'h923C6400, 60, 100, 1, 1};
        vec[8]  = '{3, 32'h803C4000, 60, 0, 0, 1};
        vec[9]  = '{3, 32'hA03C6400, 60, 0, 0, 0};
        vec[10] = '{2, 32'h3C640000, 60, 0, 0, 0};
        vec[11] = '{3, 32'h903C0000, 60, 0, 0, 0};
        vec[12] = '{4, 32'hFF90457F, 69, 127, 1, 1};
        vec[13] = '{2, 32'h45000000, 69, 0, 0, 1};

        for (int d = 0; d < 2; d++) begin
            stb_cnt[d] = 0; fe_cnt[d] = 0; last_stb[d] = 0; m_stb[d] = 0;
        end
        model_reset();
        reset = 1'b1;
        midi_rx = 1'b1;
        repeat (4) @(negedge clk);
        reset = 1'b0;

        check("reset note", int'(note0), 69);
        check("reset vol", int'(vol0), 0);
        check("reset gate", int'(gate0), 0);
        repeat (2000) @(negedge clk);
        check_dut("idle", 0);
        check("idle frame_err", fe_cnt[0] + fe_cnt[1], 0);

        for (int r = 0; r < 14; r++) begin
            s0 = stb_cnt[0];
            for (int i = 0; i < vec[r].nb; i++) begin
                bb = vec[r].bytes[31 - 8*i -: 8];
                feed(bb);
            end
            check($sformatf("row%0d note", r), int'(note0), vec[r].note);
            check($sformatf("row%0d vol", r), int'(vol0), vec[r].vol);
            check($sformatf("row%0d gate", r), int'(gate0), vec[r].gate);
            check($sformatf("row%0d strobes", r), stb_cnt[0] - s0, vec[r].stb);
            check_dut($sformatf("row%0d", r), 1);
            if (r == 0) begin
                delta = last_stb[0] - t_start;
                check("latency in window", int'(delta >= HALF + 9*BITC + 2 &&
                      delta <= HALF + 9*BITC + 6), 1);
            end
        end

        f0 = fe_cnt[0];
        f1 = fe_cnt[1];
        send_byte(8'h90, 1'b0);
        repeat (3*BITC) @(negedge clk);
        check("frame_err dut0 pulses", fe_cnt[0] - f0, 1);
        check("frame_err dut1 pulses", fe_cnt[1] - f1, 1);
        check_dut("frame_err", 0);
        feed(8'h92); feed(8'h40); feed(8'h30);
        check_dut("after frame_err", 0);

        f0 = fe_cnt[0];
        @(negedge clk);
        midi_rx = 1'b0;
        repeat (BITC/4) @(negedge clk);
        midi_rx = 1'b1;
        repeat (3*BITC) @(negedge clk);
        check("glitch frame_err", fe_cnt[0] - f0, 0);
        check_dut("glitch", 0);
        feed(8'h92); feed(8'h41); feed(8'h22);
        check_dut("after glitch", 0);

        feed(8'h90); feed(8'h3C);
        pulse_reset();
        check("midreset note", int'(note0), 69);
        check("midreset gate", int'(gate0), 0);
        check_dut("midreset", 0);
        feed(8'h64);
        check("post-reset vel note", int'(note0), 69);
        check_dut("post-reset vel", 0);

        for (int i = 0; i < 40; i++) begin
            kind = int'($urandom_range(0, 9));
            ch   = 8'($urandom_range(0, 3));
            key  = keys[$urandom_range(0, 3)];
            vel  = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom_range(1, 127));
            case (kind)
                0, 1, 2, 3: begin feed(8'h90 | ch); feed(key); feed(vel); end
                4, 5: begin feed(8'h80 | ch); feed(key); feed(vel); end
                6: begin feed(key); feed(vel); end
                7: begin
                    feed(8'h90 | ch); feed(key);
                    feed(8'hF8 + 8'($urandom_range(0, 7))); feed(vel);
                end
                8: begin feed(8'hA0 + 8'($urandom_range(0, 'h57))); feed(key); end
                default: feed(vel);
            endcase
            check_dut($sformatf("rand%0d", i), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
